mips_multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the mips CPU core; sequences PC, IM/IR, GPR, ALU and DM per instruction.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 63 ++++++
 rtl/mips_instr_decode.sv | 34 +++
 rtl/mips_multicycle_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states, datapath mux selects and the decoded instruction class.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_PASS_B = 3'd3;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class;
// anything not recognised lands in the illegal class.
module mips_instr_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  // NOTE: cls gets a full default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
          FN_JR:            cls.jr        = 1'b1;
          FN_JALR:          cls.jalr      = 1'b1;
          default:          cls.illegal   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM: sequences IF/DCD/EXE/MEM/WB per instruction, drives
// datapath enables and selects, and counts retired instructions.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             mem_wr,
  output logic [1:0]       npc_sel,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e       state_q;
  instr_class_t cls;
  logic         needs_exe;
  logic         retire;
  logic         pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, illegal_c;

  mips_instr_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign needs_exe = cls.rtype_alu | cls.ori | cls.lui | cls.lw | cls.sw | cls.beq;

  // High in the last state of every instruction, so the counter steps on the edge leaving it.
  always_comb begin
    case (state_q)
      S_DCD:   retire = ~needs_exe;
      S_EXE:   retire = cls.beq;
      S_MEM:   retire = cls.sw;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      instr_cnt <= '0;
    end else begin
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      case (state_q)
        S_IF:    state_q <= S_DCD;
        S_DCD:   state_q <= needs_exe ? S_EXE : S_IF;
        S_EXE:   state_q <= (cls.lw | cls.sw) ? S_MEM : (cls.beq ? S_IF : S_WB);
        S_MEM:   state_q <= cls.lw ? S_WB : S_IF;
        S_WB:    state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end

  always_comb begin
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    mem_wr_c  = 1'b0;
    illegal_c = 1'b0;
    npc_sel   = NPC_PC4;
    reg_dst   = REG_DST_RT;
    wd_sel    = WD_ALU;
    alu_src   = 1'b0;
    ext_op    = EXT_ZERO;
    alu_op    = ALU_ADD;
    case (state_q)
      S_IF: begin
        ir_wr_c = 1'b1;
        pc_wr_c = 1'b1;
      end
      S_DCD: begin
        illegal_c = cls.illegal;
        if (cls.j | cls.jal) begin
          pc_wr_c = 1'b1;
          npc_sel = NPC_JUMP;
        end
        if (cls.jr | cls.jalr) begin
          pc_wr_c = 1'b1;
          npc_sel = NPC_REG;
        end
        // Link value is the PC register, which already holds PC+4 after IF.
        if (cls.jal | cls.jalr) begin
          reg_wr_c = 1'b1;
          wd_sel   = WD_PC;
          reg_dst  = cls.jal ? REG_DST_RA : REG_DST_RD;
        end
      end
      S_EXE: begin
        if (cls.rtype_alu) alu_op = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
        if (cls.ori) begin
          alu_src = 1'b1;
          ext_op  = EXT_ZERO;
          alu_op  = ALU_OR;
        end
        if (cls.lui) begin
          alu_src = 1'b1;
          ext_op  = EXT_LUI;
          alu_op  = ALU_PASS_B;
        end
        if (cls.lw | cls.sw) begin
          alu_src = 1'b1;
          ext_op  = EXT_SIGN;
          alu_op  = ALU_ADD;
        end
        if (cls.beq) begin
          alu_op  = ALU_SUB;
          pc_wr_c = zero;
          npc_sel = NPC_BRANCH;
        end
      end
      S_MEM: mem_wr_c = cls.sw;
      S_WB: begin
        reg_wr_c = 1'b1;
        if (cls.rtype_alu) reg_dst = REG_DST_RD;
        wd_sel = cls.lw ? WD_MEM : WD_ALU;
      end
      default: ;
    endcase
  end

  // Reset holds the FSM in IF, whose enables must not reach the datapath.
  assign pc_wr   = pc_wr_c   & ~reset;
  assign ir_wr   = ir_wr_c   & ~reset;
  assign reg_wr  = reg_wr_c  & ~reset;
  assign mem_wr  = mem_wr_c  & ~reset;
  assign illegal = illegal_c & ~reset;
  assign state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; a second 2-bit-counter instance
// exercises counter wrap alongside the full-width instance.
module tb_mips_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h00;
  logic        zero = 1'b0;

  logic        pc_wr, ir_wr, reg_wr, mem_wr, alu_src, illegal;
  logic [1:0]  npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0]  alu_op, state;
  logic [31:0] instr_cnt;

  logic        w_pc_wr, w_ir_wr, w_reg_wr, w_mem_wr, w_alu_src, w_illegal;
  logic [1:0]  w_npc_sel, w_reg_dst, w_wd_sel, w_ext_op;
  logic [2:0]  w_alu_op, w_state;
  logic [1:0]  w_instr_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int total    = 0;

  always #5 clock = ~clock;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .npc_sel(npc_sel), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .ext_op(ext_op), .alu_op(alu_op), .illegal(illegal), .state(state),
    .instr_cnt(instr_cnt)
  );

  mips_multicycle_ctrl #(.CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_wr(w_pc_wr), .ir_wr(w_ir_wr), .reg_wr(w_reg_wr), .mem_wr(w_mem_wr),
    .npc_sel(w_npc_sel), .reg_dst(w_reg_dst), .wd_sel(w_wd_sel), .alu_src(w_alu_src),
    .ext_op(w_ext_op), .alu_op(w_alu_op), .illegal(w_illegal), .state(w_state),
    .instr_cnt(w_instr_cnt)
  );

  // Field order: state, pc_wr, ir_wr, reg_wr, mem_wr, npc_sel, reg_dst, wd_sel, alu_src, ext_op, alu_op, illegal
  function automatic logic [19:0] v(input int st, input int pc, input int ir, input int rw,
                                    input int mw, input int npc, input int rd, input int wd,
                                    input int as, input int ext, input int alu, input int ill);
    return {3'(st), 1'(pc), 1'(ir), 1'(rw), 1'(mw), 2'(npc), 2'(rd), 2'(wd),
            1'(as), 2'(ext), 3'(alu), 1'(ill)};
  endfunction

  function automatic logic [19:0] outv();
    return {state, pc_wr, ir_wr, reg_wr, mem_wr, npc_sel, reg_dst, wd_sel,
            alu_src, ext_op, alu_op, illegal};
  endfunction

  function automatic logic [19:0] outv_w();
    return {w_state, w_pc_wr, w_ir_wr, w_reg_wr, w_mem_wr, w_npc_sel, w_reg_dst, w_wd_sel,
            w_alu_src, w_ext_op, w_alu_op, w_illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cnt"},  instr_cnt, 32'(total));
    chk({tag, ".cntw"}, 32'(w_instr_cnt), 32'(total % 4));
  endtask

  // Starts at a falling edge with the FSM in IF; checks each cycle, then the return to IF.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n,
                           input logic [19:0] e0, input logic [19:0] e1,
                           input logic [19:0] e2 = '0, input logic [19:0] e3 = '0,
                           input logic [19:0] e4 = '0);
    logic [19:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    opcode = op;
    funct  = fn;
    zero   = z;
    #1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clock);
      chk($sformatf("%s.c%0d", tag, k),  32'(outv()),   32'(e[k]));
      chk($sformatf("%s.w%0d", tag, k),  32'(outv_w()), 32'(e[k]));
    end
    @(negedge clock);
    total++;
    chk({tag, ".ret"}, 32'(outv()), 32'(v(0,1,1,0,0,0,0,0,0,0,0,0)));
    chk_cnt(tag);
  endtask

  logic [19:0] ifv, d0, rst_v;

  initial begin
    ifv   = v(0,1,1,0,0,0,0,0,0,0,0,0);
    d0    = v(1,0,0,0,0,0,0,0,0,0,0,0);
    rst_v = v(0,0,0,0,0,0,0,0,0,0,0,0);

    repeat (2) @(negedge clock);
    chk("reset.out", 32'(outv()), 32'(rst_v));
    chk_cnt("reset");
    reset = 1'b0;

    run_instr("j",   6'h02, 6'h00, 1'b0, 2, ifv, v(1,1,0,0,0,2,0,0,0,0,0,0));
    run_instr("lui", 6'h0F, 6'h00, 1'b0, 4, ifv, d0,
              v(2,0,0,0,0,0,0,0,1,2,3,0), v(4,0,0,1,0,0,0,0,0,0,0,0));

    // lw interrupted in MEM by a 3-cycle reset
    opcode = 6'h23; funct = 6'h00; #1;
    chk("lwr.c0", 32'(outv()), 32'(ifv));
    @(negedge clock); chk("lwr.c1", 32'(outv()), 32'(d0));
    @(negedge clock); chk("lwr.c2", 32'(outv()), 32'(v(2,0,0,0,0,0,0,0,1,1,0,0)));
    @(negedge clock); chk("lwr.c3", 32'(outv()), 32'(v(3,0,0,0,0,0,0,0,0,0,0,0)));
    reset = 1'b1; #1;
    total = 0;
    chk("lwr.rst0", 32'(outv()), 32'(rst_v));
    chk_cnt("lwr.rst0");
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("lwr.rst%0d", k), 32'(outv()), 32'(rst_v));
      chk_cnt($sformatf("lwr.rst%0d", k));
    end
    reset = 1'b0;

    run_instr("addu", 6'h00, 6'h21, 1'b0, 4, ifv, d0,
              v(2,0,0,0,0,0,0,0,0,0,0,0), v(4,0,0,1,0,0,1,0,0,0,0,0));
    run_instr("lw",   6'h23, 6'h00, 1'b0, 5, ifv, d0,
              v(2,0,0,0,0,0,0,0,1,1,0,0), v(3,0,0,0,0,0,0,0,0,0,0,0),
              v(4,0,0,1,0,0,0,1,0,0,0,0));
    run_instr("sw",   6'h2B, 6'h00, 1'b0, 4, ifv, d0,
              v(2,0,0,0,0,0,0,0,1,1,0,0), v(3,0,0,0,1,0,0,0,0,0,0,0));
    run_instr("ill",  6'h3F, 6'h00, 1'b0, 2, ifv, v(1,0,0,0,0,0,0,0,0,0,0,1));
    run_instr("beq1", 6'h04, 6'h00, 1'b1, 3, ifv, d0, v(2,1,0,0,0,1,0,0,0,0,1,0));
    run_instr("beq0", 6'h04, 6'h00, 1'b0, 3, ifv, d0, v(2,0,0,0,0,1,0,0,0,0,1,0));
    run_instr("jal",  6'h03, 6'h00, 1'b0, 2, ifv, v(1,1,0,1,0,2,2,2,0,0,0,0));
    run_instr("jalr", 6'h00, 6'h09, 1'b0, 2, ifv, v(1,1,0,1,0,3,1,2,0,0,0,0));
    run_instr("jr",   6'h00, 6'h08, 1'b0, 2, ifv, v(1,1,0,0,0,3,0,0,0,0,0,0));
    run_instr("subu", 6'h00, 6'h23, 1'b0, 4, ifv, d0,
              v(2,0,0,0,0,0,0,0,0,0,1,0), v(4,0,0,1,0,0,1,0,0,0,0,0));
    run_instr("ori",  6'h0D, 6'h00, 1'b0, 4, ifv, d0,
              v(2,0,0,0,0,0,0,0,1,0,2,0), v(4,0,0,1,0,0,0,0,0,0,0,0));
    run_instr("rbad", 6'h00, 6'h00, 1'b0, 2, ifv, v(1,0,0,0,0,0,0,0,0,0,0,1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
